// File: rtl/i2c_pkg.sv
// Shared types for the I2C target register block: FSM state encoding and default bus address.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        WR_PTR,
        WR_DATA,
        RD_BYTE,
        RD_ACK
    } i2c_state_e;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h3C;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with registered rise/fall flags; I2C_TARGET_GLITCH_FILTER_EN adds a
// 3-sample majority filter (edge latency 3 clk plain, 5 clk filtered).
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, prev_q, rise_q, fall_q;
    logic lvl;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic h0_q, h1_q, filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0_q   <= 1'b1;
            h1_q   <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            h0_q   <= s2_q;
            h1_q   <= h0_q;
            filt_q <= (s2_q & h0_q) | (s2_q & h1_q) | (h0_q & h1_q);
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = s2_q;
`endif

    // Reset to the idle-bus level so leaving reset never produces a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= lvl;
            rise_q <= lvl & ~prev_q;
            fall_q <= ~lvl & prev_q;
        end
    end

    // prev_q is the level aligned with the registered flags.
    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an auto-incrementing byte register file exported in parallel.
// Optional SCL/SDA glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_ADDR,
    parameter int         NREGS       = 4,
    parameter int         PTR_W       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 sda_oe,
    output logic [8*NREGS-1:0]   reg_out,
    output logic                 wr_strobe,
    output logic [PTR_W-1:0]     wr_idx,
    output logic                 busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl (.clk(clk), .rst_n(rst_n), .d_i(scl_i),
                         .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
    i2c_sync_edge u_sda (.clk(clk), .rst_n(rst_n), .d_i(sda_i),
                         .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

    i2c_state_e               state_q, state_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               shift_q, shift_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [NREGS-1:0][7:0]    regs_q, regs_d;
    logic                     oe_q, oe_d;
    logic                     busy_q, busy_d;
    logic                     pend_q, pend_d;
    logic                     rw_q, rw_d;
    logic                     strobe_q, strobe_d;
    logic [PTR_W-1:0]         idx_q, idx_d;
    logic [7:0]               sampled;
    logic                     start_det, stop_det;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign sampled   = {shift_q[6:0], sda_lvl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            regs_q    <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
            rw_q      <= 1'b0;
            strobe_q  <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            regs_q    <= regs_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            rw_q      <= rw_d;
            strobe_q  <= strobe_d;
            idx_q     <= idx_d;
        end
    end

    // pend_q marks a completed byte awaiting its ACK/turnaround; rises are ignored meanwhile.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        regs_d    = regs_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        pend_d    = pend_q;
        rw_d      = rw_q;
        strobe_d  = 1'b0;
        idx_d     = idx_q;
        if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            pend_d  = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            busy_d    = 1'b1;
            pend_d    = 1'b0;
        end else if (scl_rise) begin
            unique case (state_q)
                ADDR, WR_PTR, WR_DATA: begin
                    if (!pend_q) begin
                        shift_d   = sampled;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                if (sampled[7:1] == TARGET_ADDR) begin
                                    pend_d = 1'b1;
                                    rw_d   = sampled[0];
                                end else begin
                                    state_d = IDLE;
                                end
                            end else if (state_q == WR_PTR) begin
                                ptr_d  = sampled[PTR_W-1:0];
                                pend_d = 1'b1;
                            end else begin
                                regs_d[ptr_q] = sampled;
                                strobe_d      = 1'b1;
                                idx_d         = ptr_q;
                                ptr_d         = ptr_q + 1'b1;
                                pend_d        = 1'b1;
                            end
                        end
                    end
                end
                RD_BYTE: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) pend_d = 1'b1;
                end
                RD_ACK: begin
                    if (sda_lvl) state_d = IDLE;
                    else         pend_d  = 1'b1;
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            unique case (state_q)
                ADDR: begin
                    if (pend_q) begin
                        oe_d    = 1'b1;
                        pend_d  = 1'b0;
                        state_d = ACK_ADDR;
                    end
                end
                ACK_ADDR: begin
                    bit_cnt_d = '0;
                    if (rw_q) begin
                        state_d = RD_BYTE;
                        shift_d = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                    end else begin
                        state_d = WR_PTR;
                        oe_d    = 1'b0;
                    end
                end
                WR_PTR, WR_DATA: begin
                    if (pend_q) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            pend_d  = 1'b0;
                            state_d = WR_DATA;
                        end
                    end
                end
                RD_BYTE: begin
                    if (pend_q) begin
                        oe_d    = 1'b0;
                        pend_d  = 1'b0;
                        ptr_d   = ptr_q + 1'b1;
                        state_d = RD_ACK;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                    end
                end
                RD_ACK: begin
                    if (pend_q) begin
                        pend_d    = 1'b0;
                        bit_cnt_d = '0;
                        shift_d   = regs_q[ptr_q];
                        oe_d      = ~regs_q[ptr_q][7];
                        state_d   = RD_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe    = oe_q;
    assign reg_out   = regs_q;
    assign wr_strobe = strobe_q;
    assign wr_idx    = idx_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged bus master with an open-drain SDA model.
module tb_i2c_target_regs;

    localparam int Q = 6;

    logic        clk, rst_n, scl_m, sda_m, sda_bus;
    logic        sda_oe, wr_strobe, busy;
    logic [31:0] reg_out;
    logic [1:0]  wr_idx;

    int          n_cmp = 0;
    int          n_err = 0;
    int          strobe_cnt = 0;
    logic [1:0]  idx_log [$];
    logic        oe_seen, busy_seen;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_regs #(.TARGET_ADDR(7'h3C), .NREGS(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_oe(sda_oe), .reg_out(reg_out), .wr_strobe(wr_strobe),
        .wr_idx(wr_idx), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            idx_log.push_back(wr_idx);
        end
        if (sda_oe) oe_seen = 1'b1;
        if (busy)   busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        wait_clk(Q); sda_m = b;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); r = sda_bus;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(~master_ack, r);
    endtask

    task automatic i2c_start;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop;
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    initial begin
        logic       ack, r;
        logic [7:0] d;
        logic [1:0] idx;
        int         sc0;

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        oe_seen = 1'b0; busy_seen = 1'b0;
        wait_clk(5);
        chk("rst_oe", sda_oe, 0);
        chk("rst_regs", reg_out, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_idx", wr_idx, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        wait_clk(10);

        // Write 0xA5, 0x5A at pointer 1
        i2c_start();
        send_byte(8'h78, ack); chk("wr_addr_ack", ack, 1);
        send_byte(8'h01, ack); chk("wr_ptr_ack", ack, 1);
        send_byte(8'hA5, ack); chk("wr_d0_ack", ack, 1);
        send_byte(8'h5A, ack); chk("wr_d1_ack", ack, 1);
        chk("wr_busy_mid", busy, 1);
        i2c_stop();
        chk("wr_busy_end", busy, 0);
        chk("wr_regs", reg_out, 32'h005A_A500);
        chk("wr_strobes", strobe_cnt, 2);
        idx = idx_log.pop_front(); chk("wr_idx0", idx, 1);
        idx = idx_log.pop_front(); chk("wr_idx1", idx, 2);

        // Wrong address
        oe_seen = 1'b0;
        i2c_start();
        send_byte(8'h7A, ack); chk("bad_addr_ack", ack, 0);
        send_byte(8'h00, ack); chk("bad_data_ack", ack, 0);
        chk("bad_busy_mid", busy, 1);
        i2c_stop();
        chk("bad_oe_seen", oe_seen, 0);
        chk("bad_regs", reg_out, 32'h005A_A500);
        chk("bad_busy_end", busy, 0);
        chk("bad_strobes", strobe_cnt, 2);

        // Read with repeated START from pointer 3 (wraps to 0)
        i2c_start();
        send_byte(8'h78, ack); chk("rd_addr_ack", ack, 1);
        send_byte(8'h03, ack); chk("rd_ptr_ack", ack, 1);
        i2c_start();
        send_byte(8'h79, ack); chk("rd_addr2_ack", ack, 1);
        recv_byte(1'b1, d); chk("rd_byte0", d, 8'h00);
        recv_byte(1'b0, d); chk("rd_byte1", d, 8'h00);
        wait_clk(Q);
        chk("rd_oe_released", sda_oe, 0);
        i2c_stop();

        // Preload reg3/reg0 through a wrapping write, then read them back
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(8'h03, ack);
        send_byte(8'h11, ack); chk("wrap_w0_ack", ack, 1);
        send_byte(8'h22, ack); chk("wrap_w1_ack", ack, 1);
        i2c_stop();
        idx = idx_log.pop_front(); chk("wrap_idx0", idx, 3);
        idx = idx_log.pop_front(); chk("wrap_idx1", idx, 0);
        chk("wrap_regs", reg_out, 32'h115A_A522);
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(8'h03, ack);
        i2c_start();
        send_byte(8'h79, ack);
        recv_byte(1'b1, d); chk("wrap_rd0", d, 8'h11);
        recv_byte(1'b0, d); chk("wrap_rd1", d, 8'h22);
        i2c_stop();

        // Pointer persists (now 1): bare read returns reg1
        i2c_start();
        send_byte(8'h79, ack); chk("persist_ack", ack, 1);
        recv_byte(1'b0, d); chk("persist_rd", d, 8'hA5);
        i2c_stop();

        // Abort a data byte after 4 bits
        sc0 = strobe_cnt;
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(8'h00, ack);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
        i2c_stop();
        chk("abort_regs", reg_out, 32'h115A_A522);
        chk("abort_strobes", strobe_cnt, sc0);

        // Reset while driving read bit7 of reg0 (0x22 -> bit7 = 0, SDA pulled)
        i2c_start();
        send_byte(8'h79, ack);
        wait_clk(Q);
        chk("rst_mid_driving", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", sda_oe, 0);
        chk("rst_mid_regs", reg_out, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(20);

        // 1-clk SDA glitch while SCL high
        busy_seen = 1'b0;
        sda_m = 1'b0;
        wait_clk(1);
        sda_m = 1'b1;
        wait_clk(20);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        chk("glitch_start", busy_seen, 0);
`else
        chk("glitch_start", busy_seen, 1);
`endif
        chk("glitch_busy_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
